// File: rtl/sprom_pkg.sv
// Shared helpers for the multi-channel synchronous ROM: width derivations
// used by the arbiter and the tag pipeline.
package sprom_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // A single channel still needs a 1-bit tag/pointer to keep vectors legal.
  function automatic int unsigned tag_width(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer, then moves the pointer just past the winner.
module rr_arb
  import sprom_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = tag_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0]  prio;
  logic [2*N-1:0] rot;
  logic           found;

  // Rotating a doubled copy puts the channel at prio in bit 0, so the
  // first set bit of the low half is the winner without modulo indexing.
  always_comb begin
    int unsigned c;
    c       = 0;
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    rot     = {req, req} >> prio;
    if (en) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && rot[j]) begin
          c = 32'(prio) + j;
          if (c >= N) c = c - N;
          gnt_idx = IW'(c);
          found   = 1'b1;
        end
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      gnt[k] = found && (gnt_idx == IW'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= '0;
    end else if (found) begin
      prio <= (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sprom_mc.sv
// Multi-channel synchronous ROM: NCH clients share one ROM array through a
// round-robin arbiter; responses come back tagged, 1 or 2 cycles later.
module sprom_mc
  import sprom_pkg::*;
#(
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 32,
  parameter int unsigned NCH  = 2,
  parameter int unsigned OREG = 0,
  parameter              MEM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*AW-1:0] req_addr,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH-1:0]    rsp_valid,
  output logic [DW-1:0]     rsp_data
);

  localparam int unsigned TW    = tag_width(NCH);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic [TW-1:0] gnt_idx;
  logic [AW-1:0] addr_sel;
  logic [AW-1:0] ra;
  logic          v1;
  logic [TW-1:0] t1;
  logic          out_v;
  logic [TW-1:0] out_t;
  logic [DW-1:0] rd;

  rr_arb #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    addr_sel = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (req_ready[k]) addr_sel = req_addr[k*AW +: AW];
    end
  end

  // ra only moves on a grant so the OREG=0 output stays stable when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0;
      v1 <= 1'b0;
      t1 <= '0;
    end else if (en) begin
      v1 <= |req_ready;
      t1 <= gnt_idx;
      if (|req_ready) ra <= addr_sel;
    end
  end

  assign rd = mem[ra];

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] dreg;
      logic          v2;
      logic [TW-1:0] t2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dreg <= '0;
          v2   <= 1'b0;
          t2   <= '0;
        end else if (en) begin
          dreg <= rd;
          v2   <= v1;
          t2   <= t1;
        end
      end

      assign rsp_data = dreg;
      assign out_v    = v2;
      assign out_t    = t2;
    end else begin : g_comb
      assign rsp_data = rd;
      assign out_v    = v1;
      assign out_t    = t1;
    end
  endgenerate

  // A held response is masked while disabled and reappears once en returns.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      rsp_valid[k] = en && out_v && (out_t == TW'(k));
    end
  end

endmodule

// File: tb/tb_sprom_mc.sv
// Self-checking bench for sprom_mc: directed sequences on NCH=1/2/3 and
// OREG=0/1 instances, a vector table, and a randomized run against a model.
module tb_sprom_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;

  logic [0:0]  v1, r1, s1;
  logic [9:0]  a1;
  logic [31:0] d1;

  logic [1:0]  v2, r2, s2, r2r, s2r;
  logic [19:0] a2;
  logic [31:0] d2, d2r;

  logic [2:0]  v3, r3, s3;
  logic [29:0] a3;
  logic [31:0] d3;

  int checks = 0;
  int errors = 0;

  sprom_mc #(.AW(10), .DW(32), .NCH(1), .OREG(0), .MEM_INIT_FILE("")) dut1 (
    .clk(clk), .rst(rst), .en(en), .req_valid(v1), .req_addr(a1),
    .req_ready(r1), .rsp_valid(s1), .rsp_data(d1));

  sprom_mc #(.AW(10), .DW(32), .NCH(2), .OREG(0), .MEM_INIT_FILE("")) dut2 (
    .clk(clk), .rst(rst), .en(en), .req_valid(v2), .req_addr(a2),
    .req_ready(r2), .rsp_valid(s2), .rsp_data(d2));

  sprom_mc #(.AW(10), .DW(32), .NCH(2), .OREG(1), .MEM_INIT_FILE("")) dut2r (
    .clk(clk), .rst(rst), .en(en), .req_valid(v2), .req_addr(a2),
    .req_ready(r2r), .rsp_valid(s2r), .rsp_data(d2r));

  sprom_mc #(.AW(10), .DW(32), .NCH(3), .OREG(0), .MEM_INIT_FILE("")) dut3 (
    .clk(clk), .rst(rst), .en(en), .req_valid(v3), .req_addr(a3),
    .req_ready(r3), .rsp_valid(s3), .rsp_data(d3));

  typedef struct {
    logic        en;
    logic [2:0]  v;
    logic [2:0]  rdy;
    logic [2:0]  rsv;
    logic [31:0] data;
  } vec3_t;

  typedef struct {
    int          ch;
    int unsigned due;
    logic [31:0] data;
  } rsp_t;

  vec3_t tbl [10];
  rsp_t  q1[$];
  rsp_t  q2[$];

  function automatic logic [31:0] img(input int unsigned a);
    return 32'hA500_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, n1, g, prio_m;
    int unsigned ecnt;
    logic [1:0]  er, es1, es2;
    logic [31:0] ed1, ed2;
    rsp_t e;

    for (int i = 0; i < 1024; i++) begin
      dut1.mem[i]  = img(i);
      dut2.mem[i]  = img(i);
      dut2r.mem[i] = img(i);
      dut3.mem[i]  = img(i);
    end
    rst = 1'b1; en = 1'b1;
    v1 = '0; a1 = '0; v2 = '0; a2 = '0; v3 = '0; a3 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_data_oreg0", d2, 32'hA500_0000);
    chk("rst_data_nch1", d1, 32'hA500_0000);
    chk("rst_data_oreg1", d2r, 32'h0);
    chk("rst_rsp_valid", {s1, s2, s2r, s3}, 32'h0);
    chk("rst_ready", {r1, r2, r2r, r3}, 32'h0);
    step();

    // Two-channel contention: grants alternate, responses interleave
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      v2 = 2'b11;
      a2 = {10'(32'h20 + n1), 10'(32'h10 + n0)};
      @(negedge clk);
      chk("cont_ready", r2, 32'(1 << (c % 2)));
      if (c > 0) begin
        chk("cont_rsp_valid", s2, 32'(1 << ((c - 1) % 2)));
        chk("cont_data", d2, img((((c - 1) % 2) != 0 ? 32'h20 : 32'h10) + 32'((c - 1) / 2)));
      end
      step();
      if (c % 2 == 0) n0++; else n1++;
    end
    v2 = 2'b00;
    @(negedge clk);
    chk("cont_last_valid", s2, 32'h2);
    chk("cont_last_data", d2, img(32'h23));
    step();

    // NCH=1 latency
    v1 = 1'b1; a1 = 10'h005;
    @(negedge clk);
    chk("n1_ready", r1, 32'h1);
    chk("n1_rsp_early", s1, 32'h0);
    step();
    v1 = 1'b0;
    @(negedge clk);
    chk("n1_rsp_valid", s1, 32'h1);
    chk("n1_data", d1, 32'hA500_0005);
    step();
    @(negedge clk);
    chk("n1_rsp_once", s1, 32'h0);
    step();

    // OREG=1 latency to top address
    v2 = 2'b01; a2 = {10'h000, 10'h3FF};
    @(negedge clk);
    chk("or_ready", r2r, 32'h1);
    step();
    v2 = 2'b00;
    @(negedge clk);
    chk("or_rsp_n1", s2r, 32'h0);
    chk("or0_rsp_n1", s2, 32'h1);
    chk("or0_data_n1", d2, 32'hA500_03FF);
    step();
    @(negedge clk);
    chk("or_rsp_n2", s2r, 32'h1);
    chk("or_data_n2", d2r, 32'hA500_03FF);
    step();
    @(negedge clk);
    chk("or_rsp_n3", s2r, 32'h0);
    step();

    // NCH=3 vectors: wrap of the pointer and a three-cycle en stall
    tbl[0] = '{1'b1, 3'b110, 3'b010, 3'b000, 32'hA500_0000};
    tbl[1] = '{1'b1, 3'b110, 3'b100, 3'b010, 32'hA500_0031};
    tbl[2] = '{1'b1, 3'b101, 3'b001, 3'b100, 32'hA500_0032};
    tbl[3] = '{1'b1, 3'b111, 3'b010, 3'b001, 32'hA500_0030};
    tbl[4] = '{1'b0, 3'b111, 3'b000, 3'b000, 32'hA500_0031};
    tbl[5] = '{1'b0, 3'b111, 3'b000, 3'b000, 32'hA500_0031};
    tbl[6] = '{1'b0, 3'b111, 3'b000, 3'b000, 32'hA500_0031};
    tbl[7] = '{1'b1, 3'b000, 3'b000, 3'b010, 32'hA500_0031};
    tbl[8] = '{1'b1, 3'b001, 3'b001, 3'b000, 32'hA500_0031};
    tbl[9] = '{1'b1, 3'b000, 3'b000, 3'b001, 32'hA500_0030};
    a3 = {10'h032, 10'h031, 10'h030};
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en;
      v3 = tbl[i].v;
      @(negedge clk);
      chk($sformatf("t3_ready[%0d]", i), r3, tbl[i].rdy);
      chk($sformatf("t3_rsp_valid[%0d]", i), s3, tbl[i].rsv);
      chk($sformatf("t3_data[%0d]", i), d3, tbl[i].data);
      step();
    end
    en = 1'b1; v3 = '0;

    // Randomized run on both NCH=2 instances against a transaction model
    rst = 1'b1;
    step();
    rst = 1'b0;
    prio_m = 0; ecnt = 0;
    for (int i = 0; i < 600; i++) begin
      g = -1;
      if (en) begin
        for (int j = 0; j < 2; j++) begin
          int k;
          k = (prio_m + j) % 2;
          if (g < 0 && v2[k]) g = k;
        end
      end
      er = (g >= 0) ? (2'b01 << g) : 2'b00;
      es1 = '0; es2 = '0; ed1 = '0; ed2 = '0;
      if (en) begin
        ecnt++;
        if (q1.size() > 0 && q1[0].due == ecnt) begin
          e = q1.pop_front(); es1 = 2'b01 << e.ch; ed1 = e.data;
        end
        if (q2.size() > 0 && q2[0].due == ecnt) begin
          e = q2.pop_front(); es2 = 2'b01 << e.ch; ed2 = e.data;
        end
      end
      @(negedge clk);
      chk("rnd_ready", r2, er);
      chk("rnd_ready_oreg", r2r, er);
      chk("rnd_rsp_valid", s2, es1);
      chk("rnd_rsp_valid_oreg", s2r, es2);
      if (es1 != 0) chk("rnd_data", d2, ed1);
      if (es2 != 0) chk("rnd_data_oreg", d2r, ed2);
      if (g >= 0) begin
        e.ch = g; e.data = img(32'(a2[g*10 +: 10]));
        e.due = ecnt + 1; q1.push_back(e);
        e.due = ecnt + 2; q2.push_back(e);
        prio_m = (g + 1) % 2;
      end
      step();
      if (i < 590) begin
        en = ($urandom_range(99) < 85);
        for (int k = 0; k < 2; k++) begin
          if (!v2[k] || g == k) begin
            v2[k] = ($urandom_range(99) < 60);
            a2[k*10 +: 10] = 10'($urandom);
          end else if ($urandom_range(99) < 10) begin
            v2[k] = 1'b0;
          end
        end
      end else begin
        en = 1'b1; v2 = '0;
      end
    end

    // Reset between acceptance and response
    en = 1'b1;
    v2 = 2'b01; a2 = {10'h000, 10'h044};
    @(negedge clk);
    chk("mr_accept", r2, 32'h1);
    @(posedge clk);
    #1 v2 = 2'b00;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mr_no_rsp", s2, 32'h0);
    chk("mr_no_rsp_oreg", s2r, 32'h0);
    step();
    rst = 1'b0;
    v2 = 2'b11; a2 = {10'h066, 10'h055};
    @(negedge clk);
    chk("mr_prio_zero", r2, 32'h1);
    chk("mr_no_stale", s2, 32'h0);
    chk("mr_no_stale_oreg", s2r, 32'h0);
    step();
    v2 = 2'b00;
    @(negedge clk);
    chk("mr_rsp_valid", s2, 32'h1);
    chk("mr_rsp_data", d2, img(32'h55));
    chk("mr_rsp_oreg_wait", s2r, 32'h0);
    step();
    @(negedge clk);
    chk("mr_rsp_valid_oreg", s2r, 32'h1);
    chk("mr_rsp_data_oreg", d2r, img(32'h55));
    chk("mr_rsp_once", s2, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
